// File: rtl/mod12_counter.sv
// mod12_counter: up/down modulo counter with clear, saturating load, terminal count and registered wrap pulse
module mod12_counter #(
    parameter int MODULUS = 12,
    parameter int WIDTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] max_val = WIDTH'(MODULUS - 1);

    if (MODULUS < 2 || MODULUS > 16 || (2 ** WIDTH) < MODULUS) begin : g_bad_params
        $error("mod12_counter: invalid MODULUS/WIDTH combination");
    end

    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] next_count;
    logic             next_wrap;

    always_comb begin
        at_max     = count == max_val;
        at_zero    = count == '0;
        step_val   = up_down ? (at_max ? '0 : count + 1'b1) : (at_zero ? max_val : count - 1'b1);
        next_count = clear ? '0 :
                     load  ? (load_value > max_val ? max_val : load_value) :
                     enable ? step_val : count;
        next_wrap  = !clear && !load && enable && (up_down ? at_max : at_zero);
        tc         = up_down ? at_max : at_zero;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= next_count;
            wrap  <= next_wrap;
        end
    end
endmodule

// File: tb/tb_mod12_counter.sv
// tb_mod12_counter: directed self-checking bench for mod12_counter
module tb_mod12_counter;
    logic       clk = 1'b0;
    logic       reset, enable, up_down, clear, load;
    logic [3:0] load_value;
    logic [3:0] count;
    logic       tc, wrap;
    int         total = 0;
    int         bad = 0;

    mod12_counter #(.MODULUS(12), .WIDTH(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .clear(clear), .load(load), .load_value(load_value),
        .count(count), .tc(tc), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; up_down = 1'b1; clear = 1'b0; load = 1'b0; load_value = 4'd0;
        step();
        check("reset_count", 32'(count), 0);
        check("reset_wrap", 32'(wrap), 0);
        check("reset_tc_up", 32'(tc), 0);
        reset = 1'b1; enable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            check("up_count", 32'(count), 32'(i % 12));
            check("up_tc", 32'(tc), 32'(i == 11));
            check("up_wrap", 32'(wrap), 32'(i == 12));
        end
        reset = 1'b0;
        step();
        check("rst2_count", 32'(count), 0);
        reset = 1'b1;
        for (int i = 0; i < 14; i++) step();
        check("up14_count", 32'(count), 2);
        check("up14_wrap", 32'(wrap), 0);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_count", 32'(count), 2);
            check("hold_wrap", 32'(wrap), 0);
        end
        reset = 1'b0;
        step();
        reset = 1'b1; enable = 1'b1; up_down = 1'b0;
        #1;
        check("tc_down_zero", 32'(tc), 1);
        step();
        check("down_wrap_count", 32'(count), 11);
        check("down_wrap_pulse", 32'(wrap), 1);
        check("down_tc_at11", 32'(tc), 0);
        enable = 1'b0;
        step();
        check("down_wrap_clear", 32'(wrap), 0);
        check("down_hold", 32'(count), 11);
        up_down = 1'b1;
        #1;
        check("tc_up_at11", 32'(tc), 1);
        load = 1'b1; load_value = 4'd7;
        step();
        check("load7", 32'(count), 7);
        load_value = 4'd13;
        step();
        check("load13_sat", 32'(count), 11);
        load_value = 4'd15;
        step();
        check("load15_sat", 32'(count), 11);
        enable = 1'b1; load_value = 4'd3;
        step();
        check("load_beats_enable", 32'(count), 3);
        load = 1'b0; load_value = 4'd11; load = 1'b1; enable = 1'b0;
        step();
        load = 1'b0; enable = 1'b1;
        step();
        check("wrap_after_11", 32'(wrap), 1);
        check("count_after_11", 32'(count), 0);
        load = 1'b1; load_value = 4'd5;
        step();
        check("load5", 32'(count), 5);
        check("load_wrap0", 32'(wrap), 0);
        clear = 1'b1; load_value = 4'd7;
        step();
        check("clear_beats_load", 32'(count), 0);
        clear = 1'b0; load_value = 4'd11;
        step();
        load = 1'b0; clear = 1'b1;
        step();
        check("clear_at11_count", 32'(count), 0);
        check("clear_at11_wrap", 32'(wrap), 0);
        clear = 1'b0; load = 1'b1; load_value = 4'd8;
        step();
        check("load8", 32'(count), 8);
        reset = 1'b0; load_value = 4'd6;
        step();
        check("reset_beats_load", 32'(count), 0);
        check("reset_beats_load_wrap", 32'(wrap), 0);
        reset = 1'b1; load = 1'b0; enable = 1'b1; up_down = 1'b1;
        for (int i = 0; i < 9; i++) step();
        check("count_to9", 32'(count), 9);
        reset = 1'b0;
        step();
        check("midcount_reset", 32'(count), 0);
        reset = 1'b1;
        step();
        check("resume_after_reset", 32'(count), 1);
        up_down = 1'b0;
        step();
        check("dec_to0", 32'(count), 0);
        check("dec_to0_wrap", 32'(wrap), 0);
        step();
        check("dec_wrap", 32'(count), 11);
        check("dec_wrap_pulse", 32'(wrap), 1);
        up_down = 1'b1;
        step();
        check("dir_change_up", 32'(count), 0);
        check("dir_change_wrap", 32'(wrap), 1);
        up_down = 1'b0;
        step();
        check("dir_change_down", 32'(count), 11);
        step();
        check("dec_10", 32'(count), 10);
        check("dec_10_wrap", 32'(wrap), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
